// File: rtl/tft_ctrl.sv
// tft_ctrl: 480x272 RGB565 TFT timing generator with one-cycle-early pixel requests and a frame-delayed backlight
// Ports:
//   clk_9m, sys_rst_n   pixel clock, synchronous active-low reset
//   disp_en             display enable (registered once before use)
//   pix_data            RGB565 returned by the pixel generator one clock after pix_x/pix_y
//   pix_x, pix_y        requested coordinate, 10'h3FF outside the request window
//   rgb_tft, tft_de     panel data and data enable
//   hsync, vsync        active-high syncs decoded from the registered counters
//   tft_clk, tft_bl     panel clock and backlight enable
//   frame_start         one-cycle pulse at h_cnt = v_cnt = 0
//   frame_cnt           completed-frame counter, wraps
module tft_ctrl #(
  parameter int H_SYNC   = 41,
  parameter int H_BACK   = 2,
  parameter int H_VALID  = 480,
  parameter int H_FRONT  = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 2,
  parameter int V_VALID  = 272,
  parameter int V_FRONT  = 2,
  parameter int BL_DELAY = 4
) (
  input  logic        clk_9m,
  input  logic        sys_rst_n,
  input  logic        disp_en,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] rgb_tft,
  output logic        hsync,
  output logic        vsync,
  output logic        tft_de,
  output logic        tft_clk,
  output logic        tft_bl,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);
  localparam logic [9:0] H_LAST = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
  localparam logic [9:0] V_LAST = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
  localparam logic [9:0] H_S    = 10'(H_SYNC);
  localparam logic [9:0] V_S    = 10'(V_SYNC);
  localparam logic [9:0] H_A0   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_A1   = 10'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [9:0] V_A0   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_A1   = 10'(V_SYNC + V_BACK + V_VALID - 1);
  localparam logic [9:0] H_R0   = H_A0 - 10'd1;
  localparam logic [9:0] H_R1   = H_A1 - 10'd1;
  localparam logic [7:0] BL_LAST = 8'(BL_DELAY - 1);

  typedef enum logic [1:0] {BL_OFF, BL_WAIT, BL_ON} bl_state_t;

  logic [9:0] h_cnt, v_cnt;
  logic       disp_en_q;
  logic       rst_q;
  logic       h_end, v_act, h_act, h_req, act;
  logic [7:0] bl_cnt, bl_cnt_next;
  bl_state_t  bl_state, bl_next;

  assign h_end = h_cnt == H_LAST;
  assign v_act = v_cnt >= V_A0 && v_cnt <= V_A1;
  assign h_act = h_cnt >= H_A0 && h_cnt <= H_A1;
  assign h_req = h_cnt >= H_R0 && h_cnt <= H_R1;
  assign act   = h_act && v_act;

  assign hsync   = h_cnt < H_S;
  assign vsync   = v_cnt < V_S;
  assign tft_de  = act && disp_en_q;
  assign rgb_tft = tft_de ? pix_data : 16'h0000;
  assign tft_clk = clk_9m;
  assign tft_bl  = bl_state == BL_ON;
  assign pix_x   = h_req && v_act ? h_cnt - H_R0 : 10'h3FF;
  assign pix_y   = h_req && v_act ? v_cnt - V_A0 : 10'h3FF;
  // rst_q masks the 0,0 position that the counters hold right after reset
  assign frame_start = !rst_q && h_cnt == 10'd0 && v_cnt == 10'd0;

  always_ff @(posedge clk_9m) begin
    if (!sys_rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      disp_en_q <= 1'b0;
      rst_q     <= 1'b1;
      frame_cnt <= '0;
      bl_state  <= BL_OFF;
      bl_cnt    <= '0;
    end else begin
      h_cnt     <= h_end ? 10'd0 : h_cnt + 10'd1;
      v_cnt     <= h_end ? (v_cnt == V_LAST ? 10'd0 : v_cnt + 10'd1) : v_cnt;
      disp_en_q <= disp_en;
      rst_q     <= 1'b0;
      frame_cnt <= frame_start ? frame_cnt + 8'd1 : frame_cnt;
      bl_state  <= bl_next;
      bl_cnt    <= bl_cnt_next;
    end
  end

  always_comb begin
    bl_next     = bl_state;
    bl_cnt_next = bl_cnt;
    if (!disp_en_q) begin
      bl_next     = BL_OFF;
      bl_cnt_next = '0;
    end else if (frame_start && bl_state == BL_OFF) begin
      bl_next     = BL_WAIT;
      bl_cnt_next = '0;
    end else if (frame_start && bl_state == BL_WAIT) begin
      bl_next     = bl_cnt == BL_LAST ? BL_ON : BL_WAIT;
      bl_cnt_next = bl_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_tft_ctrl.sv
// tb_tft_ctrl: phase table plus per-cycle reference model and rgb scoreboard for tft_ctrl on a shrunken raster
module tb_tft_ctrl;
  localparam int HS = 3, HB = 2, HV = 8, HF = 2;
  localparam int VS = 2, VB = 2, VV = 4, VF = 1;
  localparam int BLD = 4;
  localparam int HT = HS + HB + HV + HF;
  localparam int VT = VS + VB + VV + VF;
  localparam int F = HT * VT;

  logic        clk_9m = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        disp_en = 1'b1;
  logic [15:0] pix_data;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] rgb_tft;
  logic        hsync, vsync, tft_de, tft_clk, tft_bl, frame_start;
  logic [7:0]  frame_cnt;

  always #5 clk_9m = ~clk_9m;

  tft_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
    .BL_DELAY(BLD)
  ) dut (
    .clk_9m(clk_9m), .sys_rst_n(sys_rst_n), .disp_en(disp_en), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .rgb_tft(rgb_tft), .hsync(hsync), .vsync(vsync),
    .tft_de(tft_de), .tft_clk(tft_clk), .tft_bl(tft_bl), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  // registered loopback pixel generator
  always_ff @(posedge clk_9m) pix_data <= {pix_y[5:0], pix_x};

  int total = 0, bad = 0;
  int mh = 0, mv = 0, mfc = 0, mbf = 0;
  bit mdq = 0, minrst = 1;
  logic [15:0] sb[$];

  typedef struct {
    bit rst_n;
    bit den;
    int n;
    int fc;
    bit bl;
  } vec_t;

  task automatic advance();
    bit fs;
    if (!sys_rst_n) begin
      mh = 0; mv = 0; mfc = 0; mbf = 0; mdq = 0; minrst = 1;
      sb.delete();
    end else begin
      fs = !minrst && mh == 0 && mv == 0;
      if (fs) mfc = (mfc + 1) % 256;
      if (!mdq) mbf = 0;
      else if (fs && mbf <= BLD) mbf++;
      mdq = disp_en;
      minrst = 0;
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end
  endtask

  task automatic check_cycle();
    logic [9:0] ex, ey;
    logic [15:0] er;
    logic eact, ereq, ede, efs, vin;
    logic [48:0] exp_v, act_v;
    vin  = mv >= VS + VB && mv < VS + VB + VV;
    eact = vin && mh >= HS + HB && mh < HS + HB + HV;
    ereq = vin && mh >= HS + HB - 1 && mh < HS + HB + HV - 1;
    ex   = ereq ? 10'(mh - (HS + HB - 1)) : 10'h3FF;
    ey   = ereq ? 10'(mv - (VS + VB)) : 10'h3FF;
    ede  = eact && mdq;
    efs  = !minrst && mh == 0 && mv == 0;
    er   = 16'h0000;
    if (eact) begin
      if (sb.size() == 0) er = 16'hDEAD;
      else begin
        er = sb.pop_front();
        if (!ede) er = 16'h0000;
      end
    end
    if (ereq) sb.push_back({ey[5:0], ex});
    exp_v = {mh < HS, mv < VS, ede, mbf > BLD, efs, ex, ey, er, 8'(mfc)};
    act_v = {hsync, vsync, tft_de, tft_bl, frame_start, pix_x, pix_y, rgb_tft, frame_cnt};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL cycle h=%0d v=%0d got hs,vs,de,bl,fs=%b px=%h py=%h rgb=%h fc=%0d want %b %h %h %h %0d",
               mh, mv, act_v[48:44], pix_x, pix_y, rgb_tft, frame_cnt,
               exp_v[48:44], ex, ey, er, mfc);
    end
  endtask

  task automatic tick();
    @(posedge clk_9m);
    advance();
    @(negedge clk_9m);
    check_cycle();
  endtask

  initial begin
    vec_t tbl[9];
    int n_de, n_hs, n_vs, guard;
    tbl[0] = '{0, 1, 3, 0, 0};
    tbl[1] = '{1, 1, 2 * F + 1, 2, 0};
    tbl[2] = '{1, 1, 3 * F, 5, 1};
    tbl[3] = '{1, 0, 7, 5, 0};
    tbl[4] = '{1, 1, 5 * F + 50, 10, 1};
    tbl[5] = '{0, 1, 1, 0, 0};
    tbl[6] = '{1, 1, 255 * F + 1, 255, 1};
    tbl[7] = '{1, 1, F, 0, 1};
    tbl[8] = '{1, 0, 2, 0, 0};
    @(negedge clk_9m);
    for (int i = 0; i < 9; i++) begin
      sys_rst_n = tbl[i].rst_n;
      disp_en   = tbl[i].den;
      repeat (tbl[i].n) tick();
      total++;
      if (frame_cnt !== 8'(tbl[i].fc) || tft_bl !== tbl[i].bl) begin
        bad++;
        $display("FAIL phase %0d got fc=%0d bl=%b want fc=%0d bl=%b",
                 i, frame_cnt, tft_bl, tbl[i].fc, tbl[i].bl);
      end
    end
    disp_en = 1'b1;
    guard = 0;
    tick();
    while (!(mh == 0 && mv == 0) && guard < 2 * F) begin
      tick();
      guard++;
    end
    total++;
    if (frame_start !== 1'b1) begin
      bad++;
      $display("FAIL align got frame_start=%b want 1", frame_start);
    end
    n_de = 0; n_hs = 0; n_vs = 0;
    for (int k = 0; k < F; k++) begin
      n_de += int'(tft_de);
      n_hs += int'(hsync);
      n_vs += int'(vsync);
      tick();
    end
    total++;
    if (n_de != HV * VV || n_hs != HS * VT || n_vs != VS * HT) begin
      bad++;
      $display("FAIL frame_counts got de=%0d hs=%0d vs=%0d want %0d %0d %0d",
               n_de, n_hs, n_vs, HV * VV, HS * VT, VS * HT);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tft_ctrl.md
Name: tft_ctrl

Overview:
- Timing controller for the 480x272 RGB565 TFT panel.
- Generates the horizontal and vertical sync and data-enable timing.
- Issues pixel coordinates one cycle early to the registered pixel generator, then drives the panel RGB bus from the returned pix_data.
- Sequences panel power-up: the backlight turns on only after a programmable number of stable frames.

Parameters:
- H_SYNC, 41, hsync width in clocks
- H_BACK, 2, horizontal back porch
- H_VALID, 480, active pixels per line
- H_FRONT, 2, horizontal front porch (H_TOTAL = 525)
- V_SYNC, 10, vsync width in lines
- V_BACK, 2, vertical back porch
- V_VALID, 272, active lines
- V_FRONT, 2, vertical front porch (V_TOTAL = 286)
- BL_DELAY, 4, full frames to wait before backlight enable (1..255)

Ports:
- clk_9m  in  1  9 MHz pixel clock
- sys_rst_n  in  1  reset; synchronous, active-low
- disp_en  in  1  display enable; 0 = blank and backlight off
- pix_data  in  16  RGB565 from pixel generator; registered there, valid 1 cycle after pix_x/pix_y
- pix_x  out  10  requested column 0..479, else 10'h3FF
- pix_y  out  10  requested row 0..271, else 10'h3FF
- rgb_tft  out  16  panel RGB565
- hsync  out  1  active-high line sync
- vsync  out  1  active-high frame sync
- tft_de  out  1  panel data enable
- tft_clk  out  1  panel clock, equals clk_9m
- tft_bl  out  1  backlight enable
- frame_start  out  1  one-cycle pulse at the start of each frame
- frame_cnt  out  8  completed-frame counter, wraps 255 -> 0

Behaviour:
- One clock, clk_9m. Reset is synchronous, active-low: sys_rst_n sampled low at a clk_9m rising edge resets all state.
- Values while in reset: h_cnt = 0, v_cnt = 0, frame_cnt = 0, backlight FSM in BL_OFF, tft_bl = 0.
  - hsync = 1 and vsync = 1 (counters at 0 fall inside the sync windows).
  - tft_de = 0, rgb_tft = 0, frame_start = 0.
  - pix_x = pix_y = 10'h3FF.
- h_cnt: 0..H_TOTAL-1, increments every clock, wraps to 0.
- v_cnt: increments when h_cnt wraps; itself wraps 285 -> 0.
- hsync = (h_cnt < H_SYNC). vsync = (v_cnt < V_SYNC). Both decoded from registered counters.
- Active window:
  - h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID-1] = [43, 522]
  - v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID-1] = [12, 283]
- tft_de = active window AND disp_en_q, where disp_en_q is disp_en registered once.
- Request window is the active window shifted one clock earlier: h_cnt in [42, 521], same v range.
  - Inside it: pix_x = h_cnt - 42, pix_y = v_cnt - 12.
  - Outside it: pix_x = pix_y = 10'h3FF.
  - Row 0 request occurs at v_cnt = 12, h_cnt = 42.
- rgb_tft = tft_de ? pix_data : 16'h0000. Latency from pix_x to the matching rgb_tft sample is exactly 1 clock.
- frame_start = 1 for the single cycle where h_cnt = 0 and v_cnt = 0, excluding the reset cycle itself.
- frame_cnt increments on each frame_start.
- Backlight FSM (states BL_OFF, BL_WAIT, BL_ON), with an 8-bit wait counter bl_cnt:
  - BL_OFF: tft_bl = 0. On frame_start with disp_en_q = 1 -> BL_WAIT, bl_cnt = 0.
  - BL_WAIT: tft_bl = 0. Each frame_start increments bl_cnt. When a frame_start arrives with bl_cnt = BL_DELAY-1 -> BL_ON.
  - BL_ON: tft_bl = 1.
  - From any state, disp_en_q = 0 -> BL_OFF next cycle, bl_cnt cleared.
- Timing counters never stop because of disp_en. Only tft_de, rgb_tft and tft_bl are gated.
- disp_en edges mid-line take effect at the next clock, via disp_en_q, with no line alignment.
- Reset mid-frame: all state returns to reset values on the next edge. The counters restart at 0,0; the frame in progress is discarded, not counted.
- Widths: h_cnt and v_cnt are 10 bits. Coordinate subtraction is 10-bit unsigned, used only inside the request window, so there is no underflow.

Test Plan:
- Release reset, run 2 frames -> hsync high for 41 clocks every 525; vsync high for 10 lines every 286; frame_start period 150150 clocks; frame_cnt reaches 2.
- Loopback generator returning {6'b0, pix_x} registered -> at the first active cycle (v = 12, h = 43) rgb_tft = 0x0000; at h = 522, rgb_tft = 0x01DF (479); tft_de is high for exactly 480 clocks per active line and 272 lines per frame.
- disp_en = 1 from reset, BL_DELAY = 4 -> tft_bl rises 1 clock after the 5th frame_start (the 1st enters BL_WAIT, then 4 waited frames), and stays high.
- Deassert disp_en mid-line while BL_ON -> tft_de = 0, rgb_tft = 0 and tft_bl = 0 from the second clock after the change; hsync/vsync continue unchanged. Reassert -> backlight sequence restarts, tft_bl high again after the 5th subsequent frame_start.
- Assert sys_rst_n = 0 for 1 cycle at v_cnt = 100, h_cnt = 200 -> next cycle h_cnt = v_cnt = 0, tft_bl = 0, frame_cnt = 0, no frame_start pulse in the reset cycle.
- Run 256 frames -> frame_cnt wraps 255 -> 0 on the 256th frame_start; pix_x/pix_y read 10'h3FF throughout all blanking intervals.
